// File: rtl/apb_master_slave_subsys.sv
// ---------------------------------------------------------------------------
// apb_master_slave_subsys
//
// Self-contained APB3 subsystem: a command-driven master and a word-addressed
// register-file slave sharing one internal bus. Every transfer targets the
// fixed address TGT_ADDR. A write stores (last read data + 1), so alternating
// WRITE/READ commands walk an increment chain through the slave memory.
//
// Ports
//   pclk      in   1       clock, rising edge
//   preset_n  in   1       asynchronous reset, active HIGH despite the name
//   add_i     in   2       command: 00 NOP, 01 READ, 11 WRITE, 10 treated as NOP
//   ready_o   out  1       internal pready (high in the completing ACCESS cycle)
//   rdata_o   out  DATA_W  read data while ready_o=1 on a READ, else 0
// ---------------------------------------------------------------------------
module apb_master_slave_subsys #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] TGT_ADDR    = 'hA000,
   parameter int                MEM_DEPTH   = 16,
   parameter int                WAIT_STATES = 0
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic [1:0]        add_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] rdata_o
);

   // word index width; the slave decodes paddr[IDX_W+1:2] and ignores the rest
   localparam int       IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [2:0] WS  = 3'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // ------------------------------------------------------------------------
   // internal APB bus
   // ------------------------------------------------------------------------
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;

   // ------------------------------------------------------------------------
   // master
   // ------------------------------------------------------------------------
   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] last_rd_q;
   logic              launch;

   // 01 and 11 start a transfer; 00 and the reserved 10 do nothing
   assign launch = add_i[0];

   // state register
   always_ff @(posedge pclk or posedge preset_n) begin
      if (preset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // next-state logic; add_i is only looked at in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (launch) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: if (pready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // bus control outputs decoded from state
   always_comb begin
      psel    = 1'b0;
      penable = 1'b0;
      case (state_q)
         ST_SETUP:  psel = 1'b1;
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
         end
         default: ;
      endcase
   end

   // Address, direction and write data are loaded on the IDLE->SETUP edge so
   // they are already valid in SETUP and stay frozen through ACCESS.
   always_ff @(posedge pclk or posedge preset_n) begin
      if (preset_n) begin
         pwrite <= 1'b0;
         paddr  <= '0;
         pwdata <= '0;
      end else if (state_q == ST_IDLE && launch) begin
         pwrite <= add_i[1];
         paddr  <= TGT_ADDR;
         pwdata <= last_rd_q + DATA_W'(1);
      end
   end

   // capture read data on the completing edge of a read
   always_ff @(posedge pclk or posedge preset_n) begin
      if (preset_n)
         last_rd_q <= '0;
      else if (state_q == ST_ACCESS && pready && !pwrite)
         last_rd_q <= prdata;
   end

   // ------------------------------------------------------------------------
   // slave
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] mem [MEM_DEPTH];
   logic [2:0]        wait_cnt_q;
   logic [IDX_W-1:0]  idx;
   logic              unused_addr_bits;

   // MEM_DEPTH is expected to be a power of two so the slice wraps naturally
   assign idx              = paddr[IDX_W+1:2];
   assign unused_addr_bits = ^{paddr[ADDR_W-1:IDX_W+2], paddr[1:0]};

   assign pready = psel & penable & (wait_cnt_q == WS);

   // counts the ACCESS cycles already stalled; cleared when the transfer ends
   always_ff @(posedge pclk or posedge preset_n) begin
      if (preset_n)
         wait_cnt_q <= '0;
      else if (psel && penable) begin
         if (pready) wait_cnt_q <= '0;
         else        wait_cnt_q <= wait_cnt_q + 3'd1;
      end
   end

   // writes land at the completing edge only, so prdata in the same cycle
   // still reflects the old contents and an aborted write leaves no trace
   always_ff @(posedge pclk or posedge preset_n) begin
      if (preset_n) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (pready && pwrite) begin
         mem[idx] <= pwdata;
      end
   end

   assign prdata = (psel & penable & ~pwrite) ? mem[idx] : '0;

   // ------------------------------------------------------------------------
   // observation outputs
   // ------------------------------------------------------------------------
   assign ready_o = pready;
   // prdata is live during wait states too; only expose it on completion
   assign rdata_o = pready ? prdata : '0;

endmodule

// File: tb/tb_apb_master_slave_subsys.sv
// ---------------------------------------------------------------------------
// tb_apb_master_slave_subsys
//
// Two instances: u0 with no wait states, u1 with two. Stimulus pushes the
// hand-computed completion cycle and read data of each transfer into a
// per-instance queue; a negedge monitor pops and compares whenever the
// expected completion cycle arrives and otherwise requires ready/rdata low.
// ---------------------------------------------------------------------------
module tb_apb_master_slave_subsys;

   logic        pclk = 1'b0;
   logic        rst0, rst1;
   logic [1:0]  add0, add1;
   logic        ready0, ready1;
   logic [31:0] rdata0, rdata1;

   always #5 pclk = ~pclk;

   apb_master_slave_subsys #(.WAIT_STATES(0)) u0 (
      .pclk(pclk), .preset_n(rst0), .add_i(add0),
      .ready_o(ready0), .rdata_o(rdata0)
   );

   apb_master_slave_subsys #(.WAIT_STATES(2)) u1 (
      .pclk(pclk), .preset_n(rst1), .add_i(add1),
      .ready_o(ready1), .rdata_o(rdata1)
   );

   typedef struct {
      int          cyc;
      logic [31:0] data;
      string       name;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // monitor: compare against the scoreboard head on its due cycle
   always @(negedge pclk) begin
      if (!rst0) begin
         if (q0.size() > 0 && q0[0].cyc == cyc) begin
            chk({q0[0].name, " ready"}, 32'(ready0), 32'd1);
            chk({q0[0].name, " rdata"}, rdata0, q0[0].data);
            void'(q0.pop_front());
         end else begin
            chk("u0 quiet ready", 32'(ready0), 32'd0);
            chk("u0 quiet rdata", rdata0, 32'd0);
         end
      end
      if (!rst1) begin
         if (q1.size() > 0 && q1[0].cyc == cyc) begin
            chk({q1[0].name, " ready"}, 32'(ready1), 32'd1);
            chk({q1[0].name, " rdata"}, rdata1, q1[0].data);
            void'(q1.pop_front());
         end else begin
            chk("u1 quiet ready", 32'(ready1), 32'd0);
            chk("u1 quiet rdata", rdata1, 32'd0);
         end
      end
   end

   // one transfer: command seen by IDLE at the next edge, SETUP, then ACCESS
   // (plus wait states); returns once the master is back in IDLE
   task automatic xfer(input int d, input logic [1:0] cmd,
                       input logic [31:0] data, input string nm);
      exp_t e;
      int   ws;
      ws     = (d == 0) ? 0 : 2;
      e.cyc  = cyc + 2 + ws;
      e.data = data;
      e.name = nm;
      if (d == 0) begin q0.push_back(e); add0 = cmd; end
      else        begin q1.push_back(e); add1 = cmd; end
      @(posedge pclk); #2;
      if (d == 0) add0 = 2'b00;
      else        add1 = 2'b00;
      repeat (ws + 2) @(posedge pclk);
      #2;
   endtask

   initial begin
      exp_t e;
      rst0 = 1'b1; rst1 = 1'b1;
      add0 = 2'b00; add1 = 2'b00;
      repeat (3) @(posedge pclk);
      #2;
      chk("reset ready", 32'(ready0), 32'd0);
      chk("reset rdata", rdata0, 32'd0);
      chk("reset psel", 32'(u0.psel), 32'd0);
      rst0 = 1'b0; rst1 = 1'b0;

      // idle with NOP: bus must stay quiet
      repeat (5) begin
         @(posedge pclk); #2;
         chk("nop psel", 32'(u0.psel), 32'd0);
      end

      // increment chain
      xfer(0, 2'b11, 32'h0, "wr1");
      chk("mem after wr1", u0.mem[0], 32'h1);
      xfer(0, 2'b01, 32'h1, "rd1");
      xfer(0, 2'b11, 32'h0, "wr2");
      xfer(0, 2'b01, 32'h2, "rd2");
      xfer(0, 2'b11, 32'h0, "wr3");
      xfer(0, 2'b01, 32'h3, "rd3");

      // READ held across completion launches a second transfer
      e.data = 32'h3;
      e.cyc  = cyc + 2; e.name = "held rd a"; q0.push_back(e);
      e.cyc  = cyc + 5; e.name = "held rd b"; q0.push_back(e);
      add0 = 2'b01;
      repeat (4) @(posedge pclk);
      #2;
      add0 = 2'b00;
      repeat (3) @(posedge pclk);
      #2;

      // reserved command acts as NOP
      add0 = 2'b10;
      repeat (3) @(posedge pclk);
      #2;
      add0 = 2'b00;
      chk("reserved psel", 32'(u0.psel), 32'd0);

      // reset during ACCESS of a write
      add0 = 2'b11;
      @(posedge pclk); #2;
      add0 = 2'b00;
      @(posedge pclk); #2;
      chk("abort pre ready", 32'(ready0), 32'd1);
      rst0 = 1'b1;
      #1;
      chk("abort ready", 32'(ready0), 32'd0);
      chk("abort rdata", rdata0, 32'd0);
      chk("abort psel", 32'(u0.psel), 32'd0);
      chk("abort mem", u0.mem[0], 32'h0);
      @(posedge pclk); #2;
      rst0 = 1'b0;
      @(posedge pclk); #2;
      xfer(0, 2'b01, 32'h0, "rd after abort");

      // two wait states
      xfer(1, 2'b01, 32'h0, "ws2 rd0");
      xfer(1, 2'b11, 32'h0, "ws2 wr");
      xfer(1, 2'b01, 32'h1, "ws2 rd1");

      repeat (3) @(posedge pclk);
      #2;
      chk("u0 queue drained", 32'(q0.size()), 32'd0);
      chk("u1 queue drained", 32'(q1.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
